// File: rtl/div_ctrl.sv
// div_ctrl: radix-2 restoring DIV/DIVU sequencer with pipeline stall; define DIV_ZERO_FAST_EN to finish x/0 in one cycle
module div_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        EXE_DivStart,
  input  logic        EXE_DivSigned,
  input  logic [31:0] EXE_Dividend,
  input  logic [31:0] EXE_Divisor,
  input  logic        EXE_Flush,
  input  logic        EXE_Advance,
  output logic        EXE_DivStall,
  output logic        EXE_DivValid,
  output logic [31:0] EXE_DivQuot,
  output logic [31:0] EXE_DivRem
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [5:0] cnt;
  logic [32:0] rem, r_nx;
  logic [33:0] sh, diff;
  logic [31:0] quot, dvs, a_mag, b_mag, q_nx, q_out, r_out;
  logic qs, rs, qs_nx, rs_nx, accept, last, zero_fast;
`ifdef DIV_ZERO_FAST_EN
  assign zero_fast = EXE_Divisor == 32'd0;
`else
  assign zero_fast = 1'b0;
`endif
  // operand magnitudes, one restoring iteration, and sign-corrected results
  always_comb begin
    qs_nx = EXE_DivSigned && (EXE_Dividend[31] ^ EXE_Divisor[31]);
    rs_nx = EXE_DivSigned && EXE_Dividend[31];
    a_mag = rs_nx ? ~EXE_Dividend + 32'd1 : EXE_Dividend;
    b_mag = (EXE_DivSigned && EXE_Divisor[31]) ? ~EXE_Divisor + 32'd1 : EXE_Divisor;
    sh = {rem, quot[31]};
    diff = sh - {2'b0, dvs};
    r_nx = diff[33] ? sh[32:0] : diff[32:0];
    q_nx = {quot[30:0], ~diff[33]};
    q_out = qs ? ~q_nx + 32'd1 : q_nx;
    r_out = rs ? ~r_nx[31:0] + 32'd1 : r_nx[31:0];
  end
  // next state and stall; flush dominates everything
  always_comb begin
    accept = state == IDLE && EXE_DivStart && !EXE_Flush;
    last = state == BUSY && cnt == 6'd31;
    EXE_DivStall = accept || state == BUSY;
    state_nx = EXE_Flush ? IDLE :
               accept ? (zero_fast ? DONE : BUSY) :
               last ? DONE :
               (state == DONE && EXE_Advance) ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  end
  // divider datapath and held results
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
      rem <= '0;
      quot <= '0;
      dvs <= '0;
      qs <= 1'b0;
      rs <= 1'b0;
      EXE_DivValid <= 1'b0;
      EXE_DivQuot <= '0;
      EXE_DivRem <= '0;
    end else begin
      if (accept) begin
        rem <= '0;
        quot <= a_mag;
        dvs <= b_mag;
        qs <= qs_nx;
        rs <= rs_nx;
        cnt <= '0;
      end else if (state == BUSY && !EXE_Flush) begin
        rem <= r_nx;
        quot <= q_nx;
        cnt <= cnt + 6'd1;
      end
      if (accept && zero_fast) begin
        EXE_DivQuot <= qs_nx ? 32'd1 : 32'hFFFF_FFFF;
        EXE_DivRem <= EXE_Dividend;
      end else if (last && !EXE_Flush) begin
        EXE_DivQuot <= q_out;
        EXE_DivRem <= r_out;
      end
      EXE_DivValid <= state_nx == DONE;
    end
  end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed and random divides checked against an arithmetic reference model
module tb_div_ctrl;
  logic clk = 1'b0;
  logic resetn, start, sg, flush, adv;
  logic [31:0] dividend, divisor;
  logic stall, valid;
  logic [31:0] quot, rem;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk(clk), .resetn(resetn), .EXE_DivStart(start), .EXE_DivSigned(sg),
    .EXE_Dividend(dividend), .EXE_Divisor(divisor), .EXE_Flush(flush),
    .EXE_Advance(adv), .EXE_DivStall(stall), .EXE_DivValid(valid),
    .EXE_DivQuot(quot), .EXE_DivRem(rem)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint ma, mb, qm, rm, t;
    logic na, nb;
    na = s && a[31];
    nb = s && b[31];
    ma = na ? (longint'(1) << 32) - longint'(a) : longint'(a);
    mb = nb ? (longint'(1) << 32) - longint'(b) : longint'(b);
    if (mb == 0) begin
      qm = 64'hFFFF_FFFF;
      rm = ma;
    end else begin
      qm = ma / mb;
      rm = ma % mb;
    end
    t = (na ^ nb) ? -qm : qm;
    q = t[31:0];
    t = na ? -rm : rm;
    r = t[31:0];
  endfunction

  task automatic run_div(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er);
    int lat, n;
    lat = 33;
`ifdef DIV_ZERO_FAST_EN
    if (b == 32'd0) lat = 1;
`endif
    sg = s;
    dividend = a;
    divisor = b;
    start = 1'b1;
    #1;
    chk({tag, "_stall_accept"}, 32'(stall), 32'd1);
    n = 0;
    while (!valid && n < 40) begin
      step();
      n++;
      if (n == 1) begin
        dividend = $urandom;
        divisor = $urandom;
      end
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_quot"}, quot, eq);
    chk({tag, "_rem"}, rem, er);
    chk({tag, "_stall_done"}, 32'(stall), 32'd0);
  endtask

  task automatic advance_out(input string tag);
    adv = 1'b1;
    step();
    adv = 1'b0;
    start = 1'b0;
    #1;
    chk({tag, "_valid_after_adv"}, 32'(valid), 32'd0);
    chk({tag, "_stall_after_adv"}, 32'(stall), 32'd0);
  endtask

  initial begin
    logic [31:0] q, r, hq, hr;
    logic s;
    logic [31:0] a, b;
    int seen;
    resetn = 1'b0; start = 1'b0; sg = 1'b0; flush = 1'b0; adv = 1'b0;
    dividend = '0; divisor = '0;
    step(); step();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_quot", quot, 32'd0);
    chk("rst_rem", rem, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    resetn = 1'b1;
    step();

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002);
    advance_out("divu_100_7");
    run_div("div_m100_7", 1'b1, -32'sd100, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE);
    advance_out("div_m100_7");
    run_div("div_100_m7", 1'b1, 32'd100, -32'sd7, 32'hFFFFFFF2, 32'h00000002);
    advance_out("div_100_m7");
    run_div("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0);
    advance_out("div_ovf");
    run_div("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'h0);
    advance_out("divu_max_1");
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'h00000005);
    advance_out("divu_5_0");
    run_div("div_m7_0", 1'b1, -32'sd7, 32'd0, 32'h00000001, 32'hFFFFFFF9);
    advance_out("div_m7_0");

    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 :
          ($urandom_range(0, 2) == 0) ? 32'($urandom) : 32'($urandom_range(1, 1000));
      if (s && $urandom_range(0, 1) == 1) b = -b;
      model(s, a, b, q, r);
      run_div("rand", s, a, b, q, r);
      advance_out("rand");
    end

    run_div("hold", 1'b0, 32'd1000, 32'd33, 32'd30, 32'd10);
    hq = quot;
    hr = rem;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", 32'(valid), 32'd1);
      chk("hold_stall", 32'(stall), 32'd0);
      chk("hold_quot", quot, 32'd30);
      chk("hold_rem", rem, 32'd10);
    end
    advance_out("hold");
    chk("hold_quot_after_adv", quot, hq);
    chk("hold_rem_after_adv", rem, hr);

    sg = 1'b0; dividend = 32'd77; divisor = 32'd5; start = 1'b1;
    for (int i = 0; i < 10; i++) step();
    start = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_stall_busy", 32'(stall), 32'd1);
    step();
    flush = 1'b0;
    #1;
    chk("flush_stall_idle", 32'(stall), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (valid || stall) seen++;
    end
    chk("flush_no_valid", 32'(seen), 32'd0);

    dividend = 32'd9; divisor = 32'd0; start = 1'b1; flush = 1'b1;
    #1;
    chk("flush_start_stall", 32'(stall), 32'd0);
    step();
    start = 1'b0;
    flush = 1'b0;
    #1;
    chk("flush_start_no_busy", 32'(stall), 32'd0);
    chk("flush_start_no_valid", 32'(valid), 32'd0);

    run_div("pre_rst", 1'b0, 32'd12345, 32'd100, 32'd123, 32'd45);
    advance_out("pre_rst");
    dividend = 32'd500; divisor = 32'd3; start = 1'b1;
    for (int i = 0; i < 5; i++) step();
    resetn = 1'b0;
    start = 1'b0;
    #1;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_quot", quot, 32'd0);
    chk("arst_rem", rem, 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    step();
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (valid || stall) seen++;
    end
    chk("arst_no_residual", 32'(seen), 32'd0);

    run_div("post_rst", 1'b1, -32'sd1000, 32'd9, 32'hFFFFFF91, 32'hFFFFFFFF);
    advance_out("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
